// File: rtl/program_cnt_stack.sv
// program_cnt_stack: parametrised PC with step increment, stall and return-address stack.
// Defining PC_REL_BRANCH_EN enables the rel_pr relative branch.
module program_cnt_stack #(
    parameter int PC_W      = 8,
    parameter int STK_DEPTH = 4,
    parameter int INC_STEP  = 1,
    parameter int RESET_PC  = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               load_ar_2_pr,
    input  logic                               call_pr,
    input  logic                               ret_pr,
    input  logic                               inc_pr,
    input  logic                               rel_pr,
    input  logic                               clr_err,
    input  logic [PC_W-1:0]                    data_on_pr,
    output logic [PC_W-1:0]                    pr_on_bus,
    output logic [$clog2(STK_DEPTH+1)-1:0]     sp_depth,
    output logic                               stk_full,
    output logic                               stk_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            push_en;
    logic [PC_W-1:0] ret_addr, stk_top;
    logic [SP_W-1:0] sp_m1;
    logic [PC_W-1:0] stk_q [STK_DEPTH];

`ifndef PC_REL_BRANCH_EN
    logic unused_rel;
    assign unused_rel = rel_pr;
`endif

    assign stk_full  = sp_q == SP_W'(STK_DEPTH);
    assign stk_empty = sp_q == '0;
    assign ret_addr  = pc_q + PC_W'(INC_STEP);
    assign sp_m1     = sp_q - 1'b1;
    assign stk_top   = stk_q[IDX_W'(sp_m1)];

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (!stall) begin
            if (clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (load_ar_2_pr) pc_d = data_on_pr;
            else if (call_pr) begin
                pc_d = data_on_pr;
                if (stk_full) ovf_d = 1'b1;
                else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + 1'b1;
                end
            end else if (ret_pr) begin
                if (stk_empty) unf_d = 1'b1;
                else begin
                    pc_d = stk_top;
                    sp_d = sp_m1;
                end
            end
`ifdef PC_REL_BRANCH_EN
            // same-width add equals a sign-extended add modulo 2^PC_W
            else if (rel_pr) pc_d = pc_q + data_on_pr;
`endif
            else if (inc_pr) pc_d = ret_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= PC_W'(RESET_PC);
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // stack contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (push_en) stk_q[IDX_W'(sp_q)] <= ret_addr;
    end

    assign pr_on_bus = pc_q;
    assign sp_depth  = sp_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
endmodule

// File: tb/tb_program_cnt_stack.sv
// tb_program_cnt_stack: directed plan scenarios plus randomized run against a queue-based model.
module tb_program_cnt_stack;
    localparam logic [5:0] LD = 6'b100000, CL = 6'b010000, RT = 6'b001000,
                           RL = 6'b000100, IN = 6'b000010, CR = 6'b000001;

    logic       clk = 1'b0, reset_n = 1'b0, stall = 1'b0;
    logic       ld = 1'b0, cl = 1'b0, rt = 1'b0, rl = 1'b0, inc = 1'b0, clr = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       full, empty, ovf, unf;
    int         n_cmp = 0, n_err = 0;

    program_cnt_stack #(.PC_W(8), .STK_DEPTH(4), .INC_STEP(1), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset_n), .stall(stall), .load_ar_2_pr(ld), .call_pr(cl),
        .ret_pr(rt), .inc_pr(inc), .rel_pr(rl), .clr_err(clr), .data_on_pr(data),
        .pr_on_bus(pc), .sp_depth(sp), .stk_full(full), .stk_empty(empty),
        .ovf_err(ovf), .unf_err(unf)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {pc, sp, full, empty, ovf, unf};
    endfunction

    function automatic logic [14:0] ev(input int p, input int s, input int o, input int u);
        return {p[7:0], s[2:0], s == 4, s == 0, o[0], u[0]};
    endfunction

    task automatic step(input logic [5:0] c, input logic [7:0] d, input logic st);
        {ld, cl, rt, rl, inc, clr} = c;
        data  = d;
        stall = st;
        @(posedge clk);
        @(negedge clk);
        {ld, cl, rt, rl, inc, clr} = 6'b0;
        stall = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (obs() !== ev(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs(), ev(0, 0, 0, 0));
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_inc();
        int e [7] = '{'h01, 'h02, 'h03, 'hFE, 'hFF, 'h00, 'h01};
        for (int i = 0; i < 7; i++) begin
            if (i == 3) step(LD, 8'hFE, 1'b0);
            else step(IN, 8'h00, 1'b0);
            n_cmp++;
            if (obs() !== ev(e[i], 0, 0, 0)) begin
                n_err++;
                $display("FAIL inc[%0d]: got %h want %h", i, obs(), ev(e[i], 0, 0, 0));
            end
        end
    endtask

    task automatic test_call_ret();
        logic [5:0] c [6] = '{LD, CL, IN, CL, RT, RT};
        int d [6] = '{'h10, 'h40, 0, 'h80, 0, 0};
        int p [6] = '{'h10, 'h40, 'h41, 'h80, 'h42, 'h11};
        int s [6] = '{0, 1, 1, 2, 1, 0};
        for (int i = 0; i < 6; i++) begin
            step(c[i], 8'(d[i]), 1'b0);
            n_cmp++;
            if (obs() !== ev(p[i], s[i], 0, 0)) begin
                n_err++;
                $display("FAIL call_ret[%0d]: got %h want %h", i, obs(), ev(p[i], s[i], 0, 0));
            end
        end
    endtask

    task automatic test_overflow();
        logic [5:0] c [11] = '{LD, CL, CL, CL, CL, CL, RT, RT, RT, RT, CR};
        int d [11] = '{0, 'h10, 'h20, 'h30, 'h40, 'h50, 0, 0, 0, 0, 0};
        int p [11] = '{0, 'h10, 'h20, 'h30, 'h40, 'h50, 'h31, 'h21, 'h11, 'h01, 'h01};
        int s [11] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
        int o [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 11; i++) begin
            step(c[i], 8'(d[i]), 1'b0);
            n_cmp++;
            if (obs() !== ev(p[i], s[i], o[i], 0)) begin
                n_err++;
                $display("FAIL overflow[%0d]: got %h want %h", i, obs(), ev(p[i], s[i], o[i], 0));
            end
        end
    endtask

    task automatic test_underflow();
        logic [5:0] c [6] = '{LD, RT, CR, CR, CR | RT, CR};
        logic st [6] = '{0, 0, 1, 0, 0, 0};
        int u [6] = '{0, 1, 1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            step(c[i], 8'h22, st[i]);
            n_cmp++;
            if (obs() !== ev('h22, 0, 0, u[i])) begin
                n_err++;
                $display("FAIL underflow[%0d]: got %h want %h", i, obs(), ev('h22, 0, 0, u[i]));
            end
        end
    endtask

    task automatic test_priority_stall();
        logic [5:0] c [4] = '{LD, CL, LD | CL | IN, CL};
        int d [4] = '{'h05, 'h60, 'h33, 'h77};
        logic st [4] = '{0, 0, 0, 1};
        int p [4] = '{'h05, 'h60, 'h33, 'h33};
        int s [4] = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step(c[i], 8'(d[i]), st[i]);
            n_cmp++;
            if (obs() !== ev(p[i], s[i], 0, 0)) begin
                n_err++;
                $display("FAIL prio_stall[%0d]: got %h want %h", i, obs(), ev(p[i], s[i], 0, 0));
            end
        end
        stall = 1'b1;
        cl    = 1'b1;
        data  = 8'h77;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== ev(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_mid_stall: got %h want %h", obs(), ev(0, 0, 0, 0));
        end
        stall = 1'b0;
        cl    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(6'b0, 8'h00, 1'b0);
        n_cmp++;
        if (obs() !== ev(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL after_release: got %h want %h", obs(), ev(0, 0, 0, 0));
        end
    endtask

    task automatic test_rel();
`ifdef PC_REL_BRANCH_EN
        int p [3] = '{'h10, 'h0C, 'h11};
`else
        int p [3] = '{'h10, 'h10, 'h10};
`endif
        logic [5:0] c [3] = '{LD, RL, RL};
        int d [3] = '{'h10, 'hFC, 'h05};
        for (int i = 0; i < 3; i++) begin
            step(c[i], 8'(d[i]), 1'b0);
            n_cmp++;
            if (obs() !== ev(p[i], 0, 0, 0)) begin
                n_err++;
                $display("FAIL rel[%0d]: got %h want %h", i, obs(), ev(p[i], 0, 0, 0));
            end
        end
    endtask

    task automatic test_random();
        int   m_pc = 0;
        int   m_stk [$];
        int   m_o = 0, m_u = 0;
        logic [5:0] c;
        logic [7:0] d;
        logic st;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            c  = {$urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0};
            d  = 8'($urandom);
            st = $urandom_range(0, 7) == 0;
            if (!st) begin
                if (c[0]) begin
                    m_o = 0;
                    m_u = 0;
                end
                if (c[5]) m_pc = d;
                else if (c[4]) begin
                    if (m_stk.size() == 4) m_o = 1;
                    else m_stk.push_back((m_pc + 1) % 256);
                    m_pc = d;
                end else if (c[3]) begin
                    if (m_stk.size() == 0) m_u = 1;
                    else m_pc = m_stk.pop_back();
                end
`ifdef PC_REL_BRANCH_EN
                else if (c[2]) m_pc = (m_pc + int'($signed(d)) + 256) % 256;
`endif
                else if (c[1]) m_pc = (m_pc + 1) % 256;
            end
            step(c, d, st);
            n_cmp++;
            if (obs() !== ev(m_pc, m_stk.size(), m_o, m_u)) begin
                n_err++;
                $display("FAIL random[%0d] cmd=%b d=%h stall=%b: got %h want %h", i, c, d, st,
                         obs(), ev(m_pc, m_stk.size(), m_o, m_u));
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority_stall();
        test_rel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
